vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; successor to the fixed 1024x768 timer.

---
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to the video chain.
// master drives the bundle (the generator); slave consumes it (drawing/overlay stages).
// With VTG_FRAME_CNT_EN defined the bundle also carries the 16-bit frame_cnt.
interface vga_timing_gen_if #(
    parameter int CNT_W = 12
) ();
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             de;
    logic             sof;
    logic             eol;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0]      frame_cnt;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, de, sof, eol, frame_cnt
    );
    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, sof, eol, frame_cnt
    );
`else
    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, de, sof, eol
    );
    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, sof, eol
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Steps a pixel/line position once per clk_in with ce=1 and decodes sync,
// blanking, data-enable and start-of-frame / end-of-line strobes.
// Every output is a flop. Decodes are taken from the next-position values so
// each decoded flag lands in the same cycle as the counter value it describes.
// Optional feature: define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int CNT_W    = 12,
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             ce,
    vga_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode thresholds carry one spare bit so a sync window ending exactly
    // at 2**CNT_W still compares correctly.
    localparam int XW = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    localparam logic [XW-1:0] H_BLNK_X     = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_BEG_X = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SYNC_END_X = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] V_BLNK_X     = XW'(V_ACTIVE);
    localparam logic [XW-1:0] V_SYNC_BEG_X = XW'(V_ACTIVE + V_FP);
    localparam logic [XW-1:0] V_SYNC_END_X = XW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcount_d, hcount_q;
    logic [CNT_W-1:0] vcount_d, vcount_q;
    logic [XW-1:0]    hcount_x, vcount_x;
    logic             hsync_d,  hsync_q;
    logic             vsync_d,  vsync_q;
    logic             hblnk_d,  hblnk_q;
    logic             vblnk_d,  vblnk_q;
    logic             de_d,     de_q;
    logic             sof_d,    sof_q;
    logic             eol_d,    eol_q;

    // Raster position: one pixel per enabled clock, line wrap then frame wrap.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (ce) begin
            if (hcount_q >= H_LAST) begin
                hcount_d = '0;
                if (vcount_q >= V_LAST) begin
                    vcount_d = '0;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    // Decode from the next position; strobes only fire on an enabled step.
    always_comb begin
        hcount_x = {1'b0, hcount_d};
        vcount_x = {1'b0, vcount_d};
        hblnk_d  = (hcount_x >= H_BLNK_X);
        vblnk_d  = (vcount_x >= V_BLNK_X);
        de_d     = ~hblnk_d & ~vblnk_d;
        hsync_d  = ((hcount_x >= H_SYNC_BEG_X) && (hcount_x < H_SYNC_END_X)) ? H_POL : ~H_POL;
        vsync_d  = ((vcount_x >= V_SYNC_BEG_X) && (vcount_x < V_SYNC_END_X)) ? V_POL : ~V_POL;
        eol_d    = ce & (hcount_d == H_LAST);
        sof_d    = ce & (hcount_d == '0) & (vcount_d == '0);
    end

    // Output registers; reset parks the raster at (0,0) with syncs inactive.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= ~H_POL;
            vsync_q  <= ~V_POL;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            de_q     <= 1'b1;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            de_q     <= de_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
        end
    end

    assign vid.hcount = hcount_q;
    assign vid.vcount = vcount_q;
    assign vid.hsync  = hsync_q;
    assign vid.vsync  = vsync_q;
    assign vid.hblnk  = hblnk_q;
    assign vid.vblnk  = vblnk_q;
    assign vid.de     = de_q;
    assign vid.sof    = sof_q;
    assign vid.eol    = eol_q;

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] frame_cnt_d, frame_cnt_q;

    // Frames completed: bumps together with sof, wraps naturally at 16 bits.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (sof_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vid.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// dut_a: default horizontal timing, short vertical (8/1/2/3 -> 14 lines), active-low syncs.
// dut_b: tiny raster H 8/2/2/2, V 4/1/1/1, active-high syncs, CNT_W=4.
// Both share clock, reset and ce. frame_cnt checks apply when VTG_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;
    localparam int AH_TOT  = 1344;
    localparam int AV_TOT  = 14;
    localparam int A_FRAME = AH_TOT * AV_TOT;
    localparam int BH_TOT  = 14;
    localparam int BV_TOT  = 7;
    localparam int B_FRAME = BH_TOT * BV_TOT;

    logic clk_in = 1'b0;
    logic rst_n;
    logic ce;

    int vecs = 0;
    int errs = 0;

    int ah, av, bh, bv;
    int tick_cnt, de_cnt_a, sof_cnt_a, first_sof_a, exp_fc_a;
    logic exp_sof_a, exp_eol_a, exp_sof_b, exp_eol_b;

    always #5 clk_in = ~clk_in;

    vga_timing_gen_if #(.CNT_W(12)) vid_a ();
    vga_timing_gen_if #(.CNT_W(4))  vid_b ();

    vga_timing_gen #(
        .CNT_W(12), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3)
    ) dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .ce(ce), .vid(vid_a)
    );

    vga_timing_gen #(
        .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
    ) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .ce(ce), .vid(vid_b)
    );

    task automatic model_reset();
        ah = 0; av = 0; bh = 0; bv = 0;
        tick_cnt = 0; de_cnt_a = 0; sof_cnt_a = 0; first_sof_a = 0; exp_fc_a = 0;
        exp_sof_a = 1'b0; exp_eol_a = 1'b0; exp_sof_b = 1'b0; exp_eol_b = 1'b0;
    endtask

    // One clock with the given ce; advances the reference positions and
    // records observed de/sof activity on dut_a.
    task automatic tick(input logic ce_v);
        ce = ce_v;
        @(posedge clk_in);
        #1;
        tick_cnt++;
        exp_sof_a = 1'b0; exp_eol_a = 1'b0; exp_sof_b = 1'b0; exp_eol_b = 1'b0;
        if (ce_v) begin
            if (ah == AH_TOT - 1) begin
                ah = 0;
                av = (av == AV_TOT - 1) ? 0 : av + 1;
            end else begin
                ah++;
            end
            if (bh == BH_TOT - 1) begin
                bh = 0;
                bv = (bv == BV_TOT - 1) ? 0 : bv + 1;
            end else begin
                bh++;
            end
            exp_eol_a = (ah == AH_TOT - 1);
            exp_sof_a = (ah == 0) && (av == 0);
            exp_eol_b = (bh == BH_TOT - 1);
            exp_sof_b = (bh == 0) && (bv == 0);
            if (exp_sof_a) exp_fc_a++;
        end
        if (vid_a.de === 1'b1) de_cnt_a++;
        if (vid_a.sof === 1'b1) begin
            sof_cnt_a++;
            if (first_sof_a == 0) first_sof_a = tick_cnt;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        vecs++;
        if ({vid_a.hcount, vid_a.vcount} !== 24'd0) begin
            errs++;
            $display("FAIL reset_count_a: got h=%0d v=%0d want 0 0", vid_a.hcount, vid_a.vcount);
        end
        vecs++;
        if ({vid_a.hblnk, vid_a.vblnk, vid_a.de, vid_a.hsync, vid_a.vsync, vid_a.eol, vid_a.sof} !== 7'b0011100) begin
            errs++;
            $display("FAIL reset_flags_a: got %b want 0011100",
                {vid_a.hblnk, vid_a.vblnk, vid_a.de, vid_a.hsync, vid_a.vsync, vid_a.eol, vid_a.sof});
        end
        vecs++;
        if ({vid_b.hcount, vid_b.vcount} !== 8'd0) begin
            errs++;
            $display("FAIL reset_count_b: got h=%0d v=%0d want 0 0", vid_b.hcount, vid_b.vcount);
        end
        vecs++;
        if ({vid_b.hblnk, vid_b.vblnk, vid_b.de, vid_b.hsync, vid_b.vsync, vid_b.eol, vid_b.sof} !== 7'b0010000) begin
            errs++;
            $display("FAIL reset_flags_b: got %b want 0010000",
                {vid_b.hblnk, vid_b.vblnk, vid_b.de, vid_b.hsync, vid_b.vsync, vid_b.eol, vid_b.sof});
        end
`ifdef VTG_FRAME_CNT_EN
        vecs++;
        if (vid_a.frame_cnt !== 16'd0) begin
            errs++;
            $display("FAIL reset_frame_cnt: got %0d want 0", vid_a.frame_cnt);
        end
`endif
        @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();
    endtask

    // First line of dut_a: horizontal blanking, hsync window and eol.
    task automatic test_line0();
        logic [6:0] got, exp;
        for (int i = 0; i < AH_TOT; i++) begin
            tick(1'b1);
            vecs++;
            if ({vid_a.hcount, vid_a.vcount} !== {12'(ah), 12'(av)}) begin
                errs++;
                $display("FAIL line0_count: got h=%0d v=%0d want h=%0d v=%0d", vid_a.hcount, vid_a.vcount, ah, av);
            end
            got = {vid_a.hblnk, vid_a.hsync, vid_a.eol, vid_a.sof, vid_a.de, vid_a.vblnk, vid_a.vsync};
            exp = {ah >= 1024, !(ah >= 1048 && ah <= 1183), ah == 1343, 1'b0, ah < 1024, 1'b0, 1'b1};
            vecs++;
            if (got !== exp) begin
                errs++;
                $display("FAIL line0_flags h=%0d v=%0d: got %b want %b", ah, av, got, exp);
            end
        end
    endtask

    // Rest of the first dut_a frame: vertical decode, de total and sof timing.
    task automatic test_frame_scan();
        logic [6:0] got, exp;
        for (int i = AH_TOT; i < A_FRAME; i++) begin
            tick(1'b1);
            vecs++;
            if ({vid_a.hcount, vid_a.vcount} !== {12'(ah), 12'(av)}) begin
                errs++;
                $display("FAIL frame_count: got h=%0d v=%0d want h=%0d v=%0d", vid_a.hcount, vid_a.vcount, ah, av);
            end
            got = {vid_a.hblnk, vid_a.hsync, vid_a.eol, vid_a.sof, vid_a.de, vid_a.vblnk, vid_a.vsync};
            exp = {ah >= 1024, !(ah >= 1048 && ah <= 1183), ah == 1343, (ah == 0) && (av == 0),
                   (ah < 1024) && (av < 8), av >= 8, !(av >= 9 && av <= 10)};
            vecs++;
            if (got !== exp) begin
                errs++;
                $display("FAIL frame_flags h=%0d v=%0d: got %b want %b", ah, av, got, exp);
            end
        end
        vecs++;
        if (de_cnt_a != 1024 * 8) begin
            errs++;
            $display("FAIL frame_de_total: got %0d want %0d", de_cnt_a, 1024 * 8);
        end
        vecs++;
        if (first_sof_a != A_FRAME) begin
            errs++;
            $display("FAIL frame_first_sof: got clk %0d want %0d", first_sof_a, A_FRAME);
        end
        vecs++;
        if (sof_cnt_a != 1) begin
            errs++;
            $display("FAIL frame_sof_count: got %0d want 1", sof_cnt_a);
        end
`ifdef VTG_FRAME_CNT_EN
        vecs++;
        if (vid_a.frame_cnt !== 16'd1) begin
            errs++;
            $display("FAIL frame_cnt_after_sof: got %0d want 1", vid_a.frame_cnt);
        end
`endif
    endtask

    // ce toggling 1010 over two dut_b frames: holds on ce=0, strobes stay single-clock.
    task automatic test_ce_pacing();
        int sofs = 0;
        int sof_at = 0;
        for (int i = 0; i < 2 * B_FRAME; i++) begin
            tick((i % 2) == 0);
            vecs++;
            if ({vid_b.hcount, vid_b.vcount} !== {4'(bh), 4'(bv)}) begin
                errs++;
                $display("FAIL pace_count_b: got h=%0d v=%0d want h=%0d v=%0d", vid_b.hcount, vid_b.vcount, bh, bv);
            end
            vecs++;
            if ({vid_b.sof, vid_b.eol} !== {exp_sof_b, exp_eol_b}) begin
                errs++;
                $display("FAIL pace_strobes_b clk %0d: got %b want %b", i, {vid_b.sof, vid_b.eol}, {exp_sof_b, exp_eol_b});
            end
            vecs++;
            if ({vid_a.hcount, vid_a.vcount, vid_a.sof, vid_a.eol} !== {12'(ah), 12'(av), exp_sof_a, exp_eol_a}) begin
                errs++;
                $display("FAIL pace_a: got h=%0d v=%0d want h=%0d v=%0d", vid_a.hcount, vid_a.vcount, ah, av);
            end
            if (vid_b.sof === 1'b1) begin
                sofs++;
                sof_at = i + 1;
            end
        end
        vecs++;
        if (sofs != 1 || sof_at != 2 * B_FRAME - 1) begin
            errs++;
            $display("FAIL pace_sof: got %0d sof at clk %0d want 1 at clk %0d", sofs, sof_at, 2 * B_FRAME - 1);
        end
    endtask

    // Tiny dut_b raster with active-high syncs: every decode over one frame.
    task automatic test_small_config();
        logic [6:0] got, exp;
        for (int i = 0; i < B_FRAME; i++) begin
            tick(1'b1);
            vecs++;
            if ({vid_b.hcount, vid_b.vcount} !== {4'(bh), 4'(bv)}) begin
                errs++;
                $display("FAIL small_count: got h=%0d v=%0d want h=%0d v=%0d", vid_b.hcount, vid_b.vcount, bh, bv);
            end
            got = {vid_b.hblnk, vid_b.vblnk, vid_b.de, vid_b.hsync, vid_b.vsync, vid_b.eol, vid_b.sof};
            exp = {bh >= 8, bv >= 4, (bh < 8) && (bv < 4), (bh == 10) || (bh == 11), bv == 5,
                   bh == 13, (bh == 0) && (bv == 0)};
            vecs++;
            if (got !== exp) begin
                errs++;
                $display("FAIL small_flags h=%0d v=%0d: got %b want %b", bh, bv, got, exp);
            end
        end
    endtask

    // Async reset mid-frame at dut_a (500,5), then one full frame to the next sof.
    task automatic test_mid_frame_reset();
        int n = 0;
        while (!(ah == 500 && av == 5) && n < 20000) begin
            tick(1'b1);
            n++;
        end
        vecs++;
        if ({vid_a.hcount, vid_a.vcount} !== {12'd500, 12'd5}) begin
            errs++;
            $display("FAIL mid_reach: got h=%0d v=%0d want h=500 v=5 after %0d clks", vid_a.hcount, vid_a.vcount, n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({vid_a.hcount, vid_a.vcount, vid_a.hblnk, vid_a.vblnk, vid_a.de, vid_a.hsync, vid_a.vsync, vid_a.eol, vid_a.sof}
            !== {24'd0, 7'b0011100}) begin
            errs++;
            $display("FAIL mid_async_clear_a: got h=%0d v=%0d flags %b", vid_a.hcount, vid_a.vcount,
                {vid_a.hblnk, vid_a.vblnk, vid_a.de, vid_a.hsync, vid_a.vsync, vid_a.eol, vid_a.sof});
        end
        vecs++;
        if ({vid_b.hcount, vid_b.vcount, vid_b.hsync, vid_b.vsync} !== 10'd0) begin
            errs++;
            $display("FAIL mid_async_clear_b: got h=%0d v=%0d hs=%b vs=%b", vid_b.hcount, vid_b.vcount, vid_b.hsync, vid_b.vsync);
        end
`ifdef VTG_FRAME_CNT_EN
        vecs++;
        if (vid_a.frame_cnt !== 16'd0) begin
            errs++;
            $display("FAIL mid_frame_cnt_clear: got %0d want 0", vid_a.frame_cnt);
        end
`endif
        @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < A_FRAME; i++) begin
            tick(1'b1);
            vecs++;
            if ({vid_a.hcount, vid_a.vcount, vid_a.sof} !== {12'(ah), 12'(av), exp_sof_a}) begin
                errs++;
                $display("FAIL mid_rerun: got h=%0d v=%0d sof=%b want h=%0d v=%0d sof=%b",
                    vid_a.hcount, vid_a.vcount, vid_a.sof, ah, av, exp_sof_a);
            end
`ifdef VTG_FRAME_CNT_EN
            vecs++;
            if (vid_a.frame_cnt !== 16'(exp_fc_a)) begin
                errs++;
                $display("FAIL mid_frame_cnt: got %0d want %0d", vid_a.frame_cnt, exp_fc_a);
            end
`endif
        end
        vecs++;
        if (first_sof_a != A_FRAME || sof_cnt_a != 1) begin
            errs++;
            $display("FAIL mid_first_sof: got clk %0d (count %0d) want clk %0d (count 1)", first_sof_a, sof_cnt_a, A_FRAME);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ce = 1'b0;
        model_reset();
        test_reset();
        test_line0();
        test_frame_scan();
        test_ce_pacing();
        test_small_config();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
